// File: rtl/frame_writer.sv
// frame_writer: writes a valid/ready pixel stream into the pixel RAM in
// row-major order, starting at a base address. It raises a one-cycle
// frame_done pulse when the last pixel of a frame has been written.
// Optional build macro FRAME_DBUF_EN enables double buffering:
//   - adds a front_sel output;
//   - each frame alternates between base_addr and base_addr + IMG_W*IMG_H.
module frame_writer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] pixel_address_ram,
    output logic [DATA_W-1:0] pixel_data_ram,
    output logic              ram_we,
    output logic              busy,
    output logic              frame_done,
    output logic [9:0]        col,
    output logic [9:0]        row
`ifdef FRAME_DBUF_EN
    ,
    output logic              front_sel
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
`ifdef FRAME_DBUF_EN
    // Offset of the back buffer; wraps modulo 2^ADDR_W like all address math.
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(IMG_W * IMG_H);
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;      // address the next accepted pixel goes to
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_ram_we;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_frame_done;
    logic [9:0]        r_col;
    logic [9:0]        r_row;
`ifdef FRAME_DBUF_EN
    logic              r_front_sel;
`endif

    logic [ADDR_W-1:0] w_eff_base;
    logic              w_accept;
    logic              w_last_col;
    logic              w_last_pix;

    // Frame start address: front buffer or back buffer when double buffering.
    always_comb begin
`ifdef FRAME_DBUF_EN
        w_eff_base = r_front_sel ? (base_addr + FRAME_SIZE) : base_addr;
`else
        w_eff_base = base_addr;
`endif
    end

    // Handshake and end-of-row / end-of-frame decode.
    always_comb begin
        w_accept   = (r_state == S_WRITE) && in_valid && r_in_ready;
        w_last_col = (r_col == COL_LAST);
        w_last_pix = w_last_col && (r_row == ROW_LAST);
    end

    // Control FSM with registered outputs and a running-increment address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_ram_we     <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
`ifdef FRAME_DBUF_EN
            r_front_sel  <= 1'b0;
`endif
        end else begin
            // Write strobe and completion pulse only last one cycle.
            r_ram_we     <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        r_addr     <= w_eff_base;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        // any pixel offered on this edge is dropped
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_accept) begin
                        r_wr_addr <= r_addr;
                        r_wr_data <= in_data;
                        r_ram_we  <= 1'b1;
                        r_addr    <= r_addr + 1'b1;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 10'd1;
                        end else begin
                            r_col <= r_col + 10'd1;
                        end
                        if (w_last_pix) begin
                            r_in_ready   <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // last write and frame_done are visible this cycle
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef FRAME_DBUF_EN
                    r_front_sel <= ~r_front_sel;
`endif
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready          = r_in_ready;
    assign pixel_address_ram = r_wr_addr;
    assign pixel_data_ram    = r_wr_data;
    assign ram_we            = r_ram_we;
    assign busy              = r_busy;
    assign frame_done        = r_frame_done;
    assign col               = r_col;
    assign row               = r_row;
`ifdef FRAME_DBUF_EN
    assign front_sel         = r_front_sel;
`endif

endmodule
